// File: rtl/riscv_bus_fabric.sv
// Single-master to N-slave bus fabric: address decode, wait-state and
// read-latency handling, timeout abort and a sticky first-error record.
module riscv_bus_fabric #(
   parameter int                                     ADDR_BUS_WIDTH = 16,
   parameter int                                     NR_OF_SLAVES   = 3,
   parameter logic [NR_OF_SLAVES*ADDR_BUS_WIDTH-1:0] SLAVE_BASE     = {16'h2000, 16'h4000, 16'h8000},
   parameter logic [NR_OF_SLAVES*ADDR_BUS_WIDTH-1:0] SLAVE_MASK     = {16'hE000, 16'hC000, 16'h8000},
   parameter logic [NR_OF_SLAVES*2-1:0]              SLAVE_LATENCY  = {2'd0, 2'd1, 2'd1},
   parameter int                                     TIMEOUT_CYCLES = 15,
   parameter logic [31:0]                            ERR_DATA       = 32'hDEADBEEF
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [ADDR_BUS_WIDTH-1:0]    m_addr_i,
   input  logic [31:0]                  m_wdata_i,
   input  logic                         m_wr_w_i,
   input  logic                         m_wr_h_i,
   input  logic                         m_wr_b_i,
   input  logic                         m_rd_i,
   output logic [31:0]                  m_rdata_o,
   output logic                         m_stall_o,
   output logic [NR_OF_SLAVES-1:0]      s_cs_o,
   output logic [ADDR_BUS_WIDTH-1:0]    s_addr_o,
   output logic [31:0]                  s_wdata_o,
   output logic                         s_wr_w_o,
   output logic                         s_wr_h_o,
   output logic                         s_wr_b_o,
   input  logic [32*NR_OF_SLAVES-1:0]   s_rdata_i,
   input  logic [NR_OF_SLAVES-1:0]      s_ready_i,
   output logic                         bus_err_o,
   output logic [ADDR_BUS_WIDTH-1:0]    err_addr_o,
   input  logic                         err_clr_i
);

   localparam int SW = (NR_OF_SLAVES > 1) ? $clog2(NR_OF_SLAVES) : 1;
   localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic {IDLE, WAIT} state_t;

   state_t                      state_q, state_d;
   logic [SW-1:0]               sel_q, sel_d;
   logic [1:0]                  lat_q, lat_d;
   logic [TW-1:0]               tcnt_q, tcnt_d;
   logic                        bus_err_q;
   logic [ADDR_BUS_WIDTH-1:0]   err_addr_q;

   logic [NR_OF_SLAVES-1:0]     hit;
   logic [SW-1:0]               hit_idx;
   logic [1:0]                  hit_lat;
   logic                        req;
   logic                        err_new;
   logic                        wr_en;
   logic                        stall;
   logic [NR_OF_SLAVES-1:0]     cs;
   logic [31:0]                 rdata;

   for (genvar gi = 0; gi < NR_OF_SLAVES; gi++) begin : g_decode
      assign hit[gi] = (m_addr_i & SLAVE_MASK[gi*ADDR_BUS_WIDTH +: ADDR_BUS_WIDTH])
                       == SLAVE_BASE[gi*ADDR_BUS_WIDTH +: ADDR_BUS_WIDTH];
   end

   // Scan downwards so the lowest matching index is the one left standing.
   always_comb begin
      hit_idx = '0;
      for (int i = NR_OF_SLAVES - 1; i >= 0; i--) begin
         if (hit[i]) hit_idx = SW'(i);
      end
   end

   assign hit_lat = SLAVE_LATENCY[hit_idx*2 +: 2];
   assign req     = m_rd_i | m_wr_w_i | m_wr_h_i | m_wr_b_i;

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      lat_d   = lat_q;
      tcnt_d  = tcnt_q;
      cs      = '0;
      stall   = 1'b0;
      rdata   = '0;
      wr_en   = 1'b0;
      err_new = 1'b0;
      case (state_q)
         IDLE: begin
            if (req && (|hit)) begin
               cs = NR_OF_SLAVES'(1) << hit_idx;
               if (s_ready_i[hit_idx] && (!m_rd_i || hit_lat == 2'd0)) begin
                  if (m_rd_i) rdata = s_rdata_i[hit_idx*32 +: 32];
                  else        wr_en = 1'b1;
               end else begin
                  stall   = 1'b1;
                  sel_d   = hit_idx;
                  lat_d   = (m_rd_i && hit_lat != 2'd0) ? hit_lat - 2'd1 : 2'd0;
                  tcnt_d  = '0;
                  state_d = WAIT;
               end
            end else if (req) begin
               rdata   = ERR_DATA;
               err_new = 1'b1;
            end
         end
         WAIT: begin
            cs = NR_OF_SLAVES'(1) << sel_q;
            if (lat_q == 2'd0 && s_ready_i[sel_q]) begin
               if (m_rd_i) rdata = s_rdata_i[sel_q*32 +: 32];
               else        wr_en = 1'b1;
               lat_d   = 2'd0;
               tcnt_d  = '0;
               state_d = IDLE;
            end else if (tcnt_q == TW'(TIMEOUT_CYCLES)) begin
               rdata   = ERR_DATA;
               err_new = 1'b1;
               lat_d   = 2'd0;
               tcnt_d  = '0;
               state_d = IDLE;
            end else begin
               stall  = 1'b1;
               tcnt_d = tcnt_q + TW'(1);
               if (lat_q != 2'd0) lat_d = lat_q - 2'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= IDLE;
         sel_q      <= '0;
         lat_q      <= '0;
         tcnt_q     <= '0;
         bus_err_q  <= 1'b0;
         err_addr_q <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         lat_q   <= lat_d;
         tcnt_q  <= tcnt_d;
         // A fresh error beats a simultaneous clear and re-arms the address capture.
         if (err_new) begin
            bus_err_q <= 1'b1;
            if (!bus_err_q || err_clr_i) err_addr_q <= m_addr_i;
         end else if (err_clr_i) begin
            bus_err_q  <= 1'b0;
            err_addr_q <= '0;
         end
      end
   end

   assign m_stall_o  = rst & stall;
   assign s_cs_o     = rst ? cs : '0;
   assign m_rdata_o  = rst ? rdata : '0;
   assign s_wr_w_o   = rst & wr_en & m_wr_w_i;
   assign s_wr_h_o   = rst & wr_en & m_wr_h_i;
   assign s_wr_b_o   = rst & wr_en & m_wr_b_i;
   assign s_addr_o   = m_addr_i;
   assign s_wdata_o  = m_wdata_i;
   assign bus_err_o  = bus_err_q;
   assign err_addr_o = err_addr_q;

endmodule

// File: tb/tb_riscv_bus_fabric.sv
// Directed bench for riscv_bus_fabric: decode, latency, wait states,
// timeout abort, error recording and reset behaviour.
module tb_riscv_bus_fabric;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] m_addr;
   logic [31:0] m_wdata;
   logic        m_wr_w, m_wr_h, m_wr_b, m_rd;
   logic [31:0] m_rdata;
   logic        m_stall;
   logic [2:0]  s_cs;
   logic [15:0] s_addr;
   logic [31:0] s_wdata;
   logic        s_wr_w, s_wr_h, s_wr_b;
   logic [95:0] s_rdata;
   logic [2:0]  s_ready;
   logic        bus_err;
   logic [15:0] err_addr;
   logic        err_clr;

   int vectors     = 0;
   int miscompares = 0;
   int stalls;
   logic done;

   always #5 clk = ~clk;

   riscv_bus_fabric dut (
      .clk        (clk),
      .rst        (rst),
      .m_addr_i   (m_addr),
      .m_wdata_i  (m_wdata),
      .m_wr_w_i   (m_wr_w),
      .m_wr_h_i   (m_wr_h),
      .m_wr_b_i   (m_wr_b),
      .m_rd_i     (m_rd),
      .m_rdata_o  (m_rdata),
      .m_stall_o  (m_stall),
      .s_cs_o     (s_cs),
      .s_addr_o   (s_addr),
      .s_wdata_o  (s_wdata),
      .s_wr_w_o   (s_wr_w),
      .s_wr_h_o   (s_wr_h),
      .s_wr_b_o   (s_wr_b),
      .s_rdata_i  (s_rdata),
      .s_ready_i  (s_ready),
      .bus_err_o  (bus_err),
      .err_addr_o (err_addr),
      .err_clr_i  (err_clr)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      m_addr = '0; m_wdata = '0;
      m_wr_w = 1'b0; m_wr_h = 1'b0; m_wr_b = 1'b0; m_rd = 1'b0;
      err_clr = 1'b0;
   endtask

   initial begin
      rst     = 1'b0;
      idle_inputs();
      s_rdata = {32'h12345678, 32'h22220001, 32'h11110000};
      s_ready = 3'b111;

      // Outputs gated while reset is held, even with a live request
      next(); next();
      m_rd = 1'b1; m_wr_w = 1'b1; m_addr = 16'h2010;
      @(negedge clk);
      check("rst_stall", 32'(m_stall), 32'd0);
      check("rst_cs", 32'(s_cs), 32'd0);
      check("rst_rdata", m_rdata, 32'd0);
      check("rst_wr_w", 32'(s_wr_w), 32'd0);
      check("rst_bus_err", 32'(bus_err), 32'd0);
      check("rst_err_addr", 32'(err_addr), 32'd0);
      next();
      rst = 1'b1;
      idle_inputs();
      @(negedge clk);
      check("idle_cs", 32'(s_cs), 32'd0);
      check("idle_stall", 32'(m_stall), 32'd0);
      next();

      // Latency-0 read at 0x2010 completes in the same cycle
      m_rd = 1'b1; m_addr = 16'h2010;
      @(negedge clk);
      check("rd2010_rdata", m_rdata, 32'h12345678);
      check("rd2010_stall", 32'(m_stall), 32'd0);
      check("rd2010_cs", 32'(s_cs), 32'b100);
      next();

      // Latency-1 read at 0x8004, then 0x4000 decoded with no dead cycle
      m_addr = 16'h8004;
      @(negedge clk);
      check("rd8004_stall0", 32'(m_stall), 32'd1);
      check("rd8004_cs0", 32'(s_cs), 32'b001);
      check("rd8004_rdata0", m_rdata, 32'd0);
      next();
      @(negedge clk);
      check("rd8004_stall1", 32'(m_stall), 32'd0);
      check("rd8004_rdata1", m_rdata, 32'h11110000);
      next();
      m_addr = 16'h4000;
      @(negedge clk);
      check("rd4000_b2b_stall", 32'(m_stall), 32'd1);
      check("rd4000_b2b_cs", 32'(s_cs), 32'b010);
      next();
      @(negedge clk);
      check("rd4000_b2b_stall1", 32'(m_stall), 32'd0);
      check("rd4000_b2b_rdata", m_rdata, 32'h22220001);
      next();

      // Slave 1 not ready for 3 extra cycles beyond its latency
      s_ready = 3'b101;
      stalls = 0; done = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (c == 4) s_ready = 3'b111;
         @(negedge clk);
         if (!m_stall) begin
            done = 1'b1;
            check("rd4000_wait_rdata", m_rdata, 32'h22220001);
            break;
         end
         stalls++;
         next();
      end
      check("rd4000_wait_done", 32'(done), 32'd1);
      check("rd4000_wait_stalls", 32'(stalls), 32'd4);
      next();

      // Mapped writes complete in one cycle regardless of latency
      m_rd = 1'b0; m_wr_h = 1'b1; m_addr = 16'h2000; m_wdata = 32'hCAFE0001;
      @(negedge clk);
      check("wr2000_wr_h", 32'(s_wr_h), 32'd1);
      check("wr2000_cs", 32'(s_cs), 32'b100);
      check("wr2000_stall", 32'(m_stall), 32'd0);
      check("wr2000_wdata", s_wdata, 32'hCAFE0001);
      check("wr2000_rdata", m_rdata, 32'd0);
      next();
      m_wr_h = 1'b0; m_wr_b = 1'b1; m_addr = 16'h8000;
      @(negedge clk);
      check("wr8000_wr_b", 32'(s_wr_b), 32'd1);
      check("wr8000_stall", 32'(m_stall), 32'd0);
      check("wr8000_cs", 32'(s_cs), 32'b001);
      next();

      // Unmapped writes: suppressed, first error address kept
      m_wr_b = 1'b0; m_wr_w = 1'b1; m_addr = 16'h1000;
      @(negedge clk);
      check("wr1000_cs", 32'(s_cs), 32'd0);
      check("wr1000_wr_w", 32'(s_wr_w), 32'd0);
      check("wr1000_stall", 32'(m_stall), 32'd0);
      next();
      m_addr = 16'h1004;
      @(negedge clk);
      check("wr1000_bus_err", 32'(bus_err), 32'd1);
      check("wr1000_err_addr", 32'(err_addr), 32'h1000);
      check("wr1004_wr_w", 32'(s_wr_w), 32'd0);
      next();
      idle_inputs();
      @(negedge clk);
      check("wr1004_err_addr", 32'(err_addr), 32'h1000);
      next();

      // Clear the error record
      err_clr = 1'b1;
      next();
      idle_inputs();
      @(negedge clk);
      check("clr_bus_err", 32'(bus_err), 32'd0);
      check("clr_err_addr", 32'(err_addr), 32'd0);
      next();

      // Slave 0 never ready: timeout abort
      m_rd = 1'b1; m_addr = 16'h8000; s_ready = 3'b110;
      stalls = 0; done = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (!m_stall) begin
            done = 1'b1;
            check("tmo_rdata", m_rdata, 32'hDEADBEEF);
            break;
         end
         stalls++;
         next();
      end
      check("tmo_done", 32'(done), 32'd1);
      check("tmo_stalls", 32'(stalls), 32'd16);
      next();
      s_ready = 3'b111;
      m_addr = 16'h1000; err_clr = 1'b1;
      @(negedge clk);
      check("tmo_bus_err", 32'(bus_err), 32'd1);
      check("tmo_err_addr", 32'(err_addr), 32'h8000);
      check("clr_new_rdata", m_rdata, 32'hDEADBEEF);
      next();
      idle_inputs();
      @(negedge clk);
      check("clr_new_bus_err", 32'(bus_err), 32'd1);
      check("clr_new_err_addr", 32'(err_addr), 32'h1000);
      next();

      // Reset in the middle of WAIT
      m_rd = 1'b1; m_addr = 16'h8000; s_ready = 3'b110;
      next();
      @(negedge clk);
      check("rstw_wait_stall", 32'(m_stall), 32'd1);
      next();
      rst = 1'b0;
      @(negedge clk);
      check("rstw_low_stall", 32'(m_stall), 32'd0);
      check("rstw_low_cs", 32'(s_cs), 32'd0);
      next();
      rst = 1'b1; idle_inputs(); s_ready = 3'b111;
      @(negedge clk);
      check("rstw_stall", 32'(m_stall), 32'd0);
      check("rstw_bus_err", 32'(bus_err), 32'd0);
      check("rstw_err_addr", 32'(err_addr), 32'd0);
      next();
      m_rd = 1'b1; m_addr = 16'h2010;
      @(negedge clk);
      check("rstw_rd_rdata", m_rdata, 32'h12345678);
      check("rstw_rd_stall", 32'(m_stall), 32'd0);
      next();
      idle_inputs();
      next();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/riscv_bus_fabric.md
RISCV_BUS_FABRIC -- requirements
Module: riscv_bus_fabric

Interface
REQ-001 SHALL have parameter ADDR_BUS_WIDTH, default 16: master/slave address width.
REQ-002 SHALL have parameter NR_OF_SLAVES, default 3, range 1..8: number of slave ports.
REQ-003 SHALL have parameter SLAVE_BASE, default {16'h2000,16'h4000,16'h8000}: packed per-slave base address, slave 0 in the LSBs.
REQ-004 SHALL have parameter SLAVE_MASK, default {16'hE000,16'hC000,16'h8000}: packed per-slave decode mask.
REQ-005 SHALL have parameter SLAVE_LATENCY, default {2'd0,2'd1,2'd1}: packed per-slave read latency, 0..3 cycles.
REQ-006 SHALL have parameter TIMEOUT_CYCLES, default 15: maximum WAIT cycles before abort.
REQ-007 SHALL have parameter ERR_DATA, default 32'hDEADBEEF: read data returned on error.
REQ-008 clk  in  1  single clock; all state changes on rising edge.
REQ-009 rst  in  1  reset: synchronous, active-low.
REQ-010 m_addr_i  in  ADDR_BUS_WIDTH  master address; master holds it, and all m_* inputs, while m_stall_o=1.
REQ-011 m_wdata_i  in  32  master write data.
REQ-012 m_wr_w_i / m_wr_h_i / m_wr_b_i  in  1 each  word/half/byte write strobes.
REQ-013 m_rd_i  in  1  read request.
REQ-014 m_rdata_o  out  32  read data to master.
REQ-015 m_stall_o  out  1  master stall.
REQ-016 s_cs_o  out  NR_OF_SLAVES  one-hot slave select.
REQ-017 s_addr_o / s_wdata_o  out  ADDR_BUS_WIDTH / 32  pass-through of m_addr_i / m_wdata_i.
REQ-018 s_wr_w_o / s_wr_h_o / s_wr_b_o  out  1 each  master strobes gated by a valid selection.
REQ-019 s_rdata_i  in  32*NR_OF_SLAVES  packed slave read data, slave 0 in the LSBs.
REQ-020 s_ready_i  in  NR_OF_SLAVES  slave ready; low inserts wait states.
REQ-021 bus_err_o  out  1  sticky error flag.
REQ-022 err_addr_o  out  ADDR_BUS_WIDTH  address of first error since clear.
REQ-023 err_clr_i  in  1  clears bus_err_o and err_addr_o.

Function
REQ-024 Request = m_rd_i | m_wr_w_i | m_wr_h_i | m_wr_b_i; slave i hits when (m_addr_i & MASK_i) == BASE_i; on overlap the lowest index SHALL win.
REQ-025 FSM SHALL have two states: IDLE and WAIT.
REQ-026 IDLE, no request: m_stall_o=0, s_cs_o=0.
REQ-027 IDLE, hit, read, latency 0, ready high: s_cs_o asserted, m_rdata_o = s_rdata_i[sel] combinationally, m_stall_o=0, stay IDLE.
REQ-028 IDLE, hit, write, ready high: strobes passed to slave, m_stall_o=0, write completes that cycle regardless of latency.
REQ-029 IDLE, hit, otherwise (read latency L>0 or ready low): m_stall_o=1; register sel; latency counter = L-1 for reads (0 if L=0), 0 for writes; timeout counter = 0; go WAIT.
REQ-030 WAIT: s_cs_o from registered sel; latency counter decrements to 0 and holds; timeout counter increments each cycle.
REQ-031 WAIT, latency counter 0 and s_ready_i[sel]=1: m_stall_o=0, m_rdata_o = s_rdata_i[sel], write strobes passed once; go IDLE.
REQ-032 WAIT, timeout counter = TIMEOUT_CYCLES without completion: m_stall_o=0, m_rdata_o = ERR_DATA, write strobes suppressed, error recorded; go IDLE.
REQ-033 IDLE, request with no hit: s_cs_o=0, write strobes suppressed, m_stall_o=0, m_rdata_o = ERR_DATA, error recorded.
REQ-034 Error record: bus_err_o set; err_addr_o latched only if bus_err_o was 0 (first error kept).
REQ-035 err_clr_i with simultaneous new error: new error SHALL win and its address SHALL be latched.
REQ-036 m_rdata_o SHALL be 0 whenever no read completes that cycle.
REQ-037 Back-to-back requests: the cycle after completion SHALL decode the next request in IDLE with no dead cycle.

Reset
REQ-038 rst low at a clock edge, including mid-WAIT, SHALL force IDLE, clear both counters and registered sel, bus_err_o=0, err_addr_o=0.
REQ-039 While rst is low: m_stall_o=0, s_cs_o=0, all s_wr_*_o=0, m_rdata_o=0.

Verification
REQ-040 Read 0x2010 with s_rdata_i[2]=0x12345678, ready high -> same-cycle m_rdata_o=0x12345678, m_stall_o=0, s_cs_o=3'b100.
REQ-041 Read 0x8004, latency 1 -> m_stall_o=1 for 1 cycle, then rdata = slave 0 data, stall 0; next read at 0x4000 decoded immediately.
REQ-042 Read 0x4000 with s_ready_i[1] low 3 extra cycles -> stall for 4 cycles total, then data returned.
REQ-043 Write to 0x1000 -> no s_cs_o, no strobes, bus_err_o=1, err_addr_o=0x1000; second error at 0x1004 leaves err_addr_o=0x1000.
REQ-044 s_ready_i[0] held low -> abort after 15 WAIT cycles, rdata=0xDEADBEEF, bus_err_o=1; err_clr_i plus simultaneous unmapped access -> bus_err_o stays 1 with the new address.
REQ-045 rst low during WAIT -> next cycle IDLE, m_stall_o=0, bus_err_o=0, and a subsequent read completes normally.
